// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared types for the LCD SPI arbiter slice: FSM state encoding, the one-hot
// grant type with its named values, and the tie-break picker used in IDLE.
// Optional feature macro used by the slice: SPI_ARB_RR_EN (round-robin ties).
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_REQ0 = 2'b01;
    localparam grant_t GRANT_REQ1 = 2'b10;

    // Chooses the next owner from the two valid flags. preferReq1 only
    // matters when both requesters are valid at the same time.
    function automatic grant_t pickGrant(input logic valid0,
                                         input logic valid1,
                                         input logic preferReq1);
        grant_t result;
        result = GRANT_NONE;
        if (valid0 && valid1) begin
            result = preferReq1 ? GRANT_REQ1 : GRANT_REQ0;
        end else if (valid0) begin
            result = GRANT_REQ0;
        end else if (valid1) begin
            result = GRANT_REQ1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_arb_timeout.sv
// ---------------------------------------------------------------------------
// spi_arb_timeout
// Saturating idle counter used to detect an owner that stalls mid-packet.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   clear_i     : force the count back to zero (has priority over enable_i)
//   enable_i    : count one idle cycle
//   expire_o    : combinational, high while enabled with the count at
//                 TIMEOUT_CYCLES-1 (the last allowed idle cycle)
// ---------------------------------------------------------------------------
module spi_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] CNT_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] cntQ;
    logic [TMO_W-1:0] cntD;

    // Count holds at CNT_MAX rather than wrapping, so a stuck owner can never
    // slip past the expiry point.
    always_comb begin
        cntD = cntQ;
        if (clear_i) begin
            cntD = '0;
        end else if (enable_i && (cntQ != CNT_MAX)) begin
            cntD = cntQ + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign expire_o = enable_i && (cntQ == CNT_MAX);

endmodule

// File: rtl/lcd_spi_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_spi_arbiter
// Shares one SPI/LCD transmit engine between the CPU MMIO path (req0) and the
// button-driven command sequencer (req1). Ownership is per packet: the winner
// keeps the engine and chip select until its byte flagged last has shifted.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   reqN_valid/data/dc/last, reqN_ready: byte-stream requesters (N = 0, 1)
//   spi_start/data/dc/hold_cs          : command side of the SPI engine
//   spi_busy, spi_done                 : status from the SPI engine
//   grant                              : one-hot owner, 00 when idle
//   timeout_err                        : one-cycle pulse on forced release
// Build option: define SPI_ARB_RR_EN for round-robin tie breaking; without
// it req0 always wins a simultaneous request.
// ---------------------------------------------------------------------------
module lcd_spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_dc,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_dc,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       spi_start,
    output logic [7:0] spi_data,
    output logic       spi_dc,
    output logic       spi_hold_cs,
    input  logic       spi_busy,
    input  logic       spi_done,
    output logic [1:0] grant,
    output logic       timeout_err
);

    arb_state_e state_q, state_d;
    grant_t     grant_q, grant_d;
    logic       hold_q, hold_d;
    logic       start_q, start_d;
    logic       err_q, err_d;
    logic [7:0] data_q, data_d;
    logic       dc_q, dc_d;
    logic       last_q, last_d;
    logic       preferReq1;

`ifdef SPI_ARB_RR_EN
    logic rr_q, rr_d;
    assign preferReq1 = rr_q;
`else
    assign preferReq1 = 1'b0;
`endif

    // Mux of the current owner's stream; grant_q is one-hot while in ISSUE.
    logic       selValid, selDc, selLast, inIssue, transfer, expire;
    logic [7:0] selData;

    assign selValid = grant_q[1] ? req1_valid : req0_valid;
    assign selData  = grant_q[1] ? req1_data  : req0_data;
    assign selDc    = grant_q[1] ? req1_dc    : req0_dc;
    assign selLast  = grant_q[1] ? req1_last  : req0_last;
    assign inIssue  = (state_q == ISSUE);
    assign transfer = inIssue && selValid && !spi_busy;

    assign req0_ready = inIssue && grant_q[0] && !spi_busy;
    assign req1_ready = inIssue && grant_q[1] && !spi_busy;

    // Idle counting only runs while the owner is in ISSUE with nothing to
    // offer; any other state restarts it.
    spi_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear_i (!inIssue),
        .enable_i(inIssue && !selValid),
        .expire_o(expire)
    );

    // Next-state logic. A release drops grant and chip select together and
    // always passes through IDLE, which guarantees a CS-high gap between
    // owners. spi_done is only honoured in WAIT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        dc_d    = dc_q;
        last_d  = last_q;
`ifdef SPI_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = pickGrant(req0_valid, req1_valid, preferReq1);
                    hold_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (transfer) begin
                    data_d  = selData;
                    dc_d    = selDc;
                    last_d  = selLast;
                    start_d = 1'b1;
                    state_d = WAIT;
                end else if (expire) begin
                    grant_d = GRANT_NONE;
                    hold_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
`ifdef SPI_ARB_RR_EN
                    rr_d    = (grant_q == GRANT_REQ0);
`endif
                end
            end
            WAIT: begin
                if (spi_done) begin
                    if (last_q) begin
                        grant_d = GRANT_NONE;
                        hold_d  = 1'b0;
                        state_d = IDLE;
`ifdef SPI_ARB_RR_EN
                        rr_d    = (grant_q == GRANT_REQ0);
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
            hold_q  <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            dc_q    <= 1'b0;
            last_q  <= 1'b0;
`ifdef SPI_ARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            err_q   <= err_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
`ifdef SPI_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign spi_start   = start_q;
    assign spi_data    = data_q;
    assign spi_dc      = dc_q;
    assign spi_hold_cs = hold_q;
    assign grant       = grant_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_arbiter
// Directed bench for lcd_spi_arbiter with a short timeout so the forced
// release is reached quickly. The SPI engine is played by engineDone.
// ---------------------------------------------------------------------------
module tb_lcd_spi_arbiter;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_dc, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_dc, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       spi_start, spi_dc, spi_hold_cs, spi_busy, spi_done;
    logic [7:0] spi_data;
    logic [1:0] grant;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [1:0] expTieGrant;
    logic [7:0] expTieData;

    lcd_spi_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_dc    (req0_dc),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_dc    (req1_dc),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_dc     (spi_dc),
        .spi_hold_cs(spi_hold_cs),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled 1 time unit after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic dc0, input logic l0,
                                 input logic v1, input logic [7:0] d1,
                                 input logic dc1, input logic l1);
        req0_valid = v0; req0_data = d0; req0_dc = dc0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_dc = dc1; req1_last = l1;
    endtask

    // Engine model: called in the spi_start cycle; goes busy, then pulses
    // done with busy dropping. Returns just after the edge that saw done.
    task automatic engineDone();
        tick();
        spi_busy = 1'b1;
        tick();
        spi_busy = 1'b0;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        tick();
        tick();
        checkOutput("rst_grant", {6'd0, grant}, 8'h00);
        checkOutput("rst_hold", {7'd0, spi_hold_cs}, 8'h00);
        checkOutput("rst_start", {7'd0, spi_start}, 8'h00);
        checkOutput("rst_data", spi_data, 8'h00);
        checkOutput("rst_err", {7'd0, timeout_err}, 8'h00);
        reset = 1'b0;
        tick();

        // req0 three-byte packet 2A/00/10
        $display("[TB] packet from req0");
        applyStimulus(1, 8'h2A, 0, 0, 0, 8'h00, 0, 0);
        tick();
        checkOutput("p1_grant", {6'd0, grant}, 8'h01);
        checkOutput("p1_hold", {7'd0, spi_hold_cs}, 8'h01);
        checkOutput("p1_ready0", {7'd0, req0_ready}, 8'h01);
        checkOutput("p1_nostart", {7'd0, spi_start}, 8'h00);
        tick();
        checkOutput("p1_start0", {7'd0, spi_start}, 8'h01);
        checkOutput("p1_data0", spi_data, 8'h2A);
        checkOutput("p1_dc0", {7'd0, spi_dc}, 8'h00);
        checkOutput("p1_wait_ready", {7'd0, req0_ready}, 8'h00);
        applyStimulus(1, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        engineDone();
        checkOutput("p1_ready_b1", {7'd0, req0_ready}, 8'h01);
        checkOutput("p1_hold_b1", {7'd0, spi_hold_cs}, 8'h01);
        tick();
        checkOutput("p1_start1", {7'd0, spi_start}, 8'h01);
        checkOutput("p1_data1", spi_data, 8'h00);
        checkOutput("p1_dc1", {7'd0, spi_dc}, 8'h01);
        applyStimulus(1, 8'h10, 1, 1, 0, 8'h00, 0, 0);
        engineDone();
        checkOutput("p1_ready_b2", {7'd0, req0_ready}, 8'h01);
        tick();
        checkOutput("p1_start2", {7'd0, spi_start}, 8'h01);
        checkOutput("p1_data2", spi_data, 8'h10);
        checkOutput("p1_hold_b2", {7'd0, spi_hold_cs}, 8'h01);
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        engineDone();
        checkOutput("p1_rel_grant", {6'd0, grant}, 8'h00);
        checkOutput("p1_rel_hold", {7'd0, spi_hold_cs}, 8'h00);

        // Simultaneous requests straight out of reset
        $display("[TB] tie handling");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1, 8'h11, 0, 1, 1, 8'h22, 1, 1);
        tick();
        checkOutput("tie1_grant", {6'd0, grant}, 8'h01);
        checkOutput("tie1_ready1", {7'd0, req1_ready}, 8'h00);
        tick();
        checkOutput("tie1_data", spi_data, 8'h11);
        req0_valid = 1'b0;
        engineDone();
        checkOutput("tie1_rel", {6'd0, grant}, 8'h00);
`ifdef SPI_ARB_RR_EN
        expTieGrant = 2'b10;
        expTieData  = 8'h22;
`else
        expTieGrant = 2'b01;
        expTieData  = 8'h11;
`endif
        req0_valid = 1'b1;
        tick();
        checkOutput("tie2_grant", {6'd0, grant}, {6'd0, expTieGrant});
        tick();
        checkOutput("tie2_data", spi_data, expTieData);
        applyStimulus(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        engineDone();
        checkOutput("tie2_rel", {6'd0, grant}, 8'h00);

        // req1 arrives while req0 owns the engine
        $display("[TB] blocked requester");
        applyStimulus(1, 8'hAA, 0, 0, 0, 8'h00, 0, 0);
        tick();
        applyStimulus(1, 8'hAA, 0, 0, 1, 8'h55, 1, 1);
        checkOutput("blk_ready1_a", {7'd0, req1_ready}, 8'h00);
        tick();
        checkOutput("blk_dataA", spi_data, 8'hAA);
        applyStimulus(1, 8'hBB, 1, 1, 1, 8'h55, 1, 1);
        engineDone();
        checkOutput("blk_grant_mid", {6'd0, grant}, 8'h01);
        checkOutput("blk_ready1_b", {7'd0, req1_ready}, 8'h00);
        tick();
        checkOutput("blk_dataB", spi_data, 8'hBB);
        req0_valid = 1'b0;
        engineDone();
        checkOutput("blk_gap_grant", {6'd0, grant}, 8'h00);
        checkOutput("blk_gap_hold", {7'd0, spi_hold_cs}, 8'h00);
        checkOutput("blk_gap_ready1", {7'd0, req1_ready}, 8'h00);
        tick();
        checkOutput("blk_grant1", {6'd0, grant}, 8'h02);
        checkOutput("blk_ready1_c", {7'd0, req1_ready}, 8'h01);
        tick();
        checkOutput("blk_data55", spi_data, 8'h55);
        checkOutput("blk_dc55", {7'd0, spi_dc}, 8'h01);
        req1_valid = 1'b0;
        engineDone();

        // Owner stalls mid-packet: forced release TMO cycles after ISSUE
        $display("[TB] timeout");
        applyStimulus(1, 8'hC0, 0, 0, 0, 8'h00, 0, 0);
        tick();
        tick();
        req0_valid = 1'b0;
        engineDone();
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
        end
        checkOutput("tmo_before", {7'd0, timeout_err}, 8'h00);
        checkOutput("tmo_hold_before", {7'd0, spi_hold_cs}, 8'h01);
        tick();
        checkOutput("tmo_pulse", {7'd0, timeout_err}, 8'h01);
        checkOutput("tmo_hold", {7'd0, spi_hold_cs}, 8'h00);
        checkOutput("tmo_grant", {6'd0, grant}, 8'h00);
        tick();
        checkOutput("tmo_pulse_end", {7'd0, timeout_err}, 8'h00);

        // Engine busy while in ISSUE
        $display("[TB] busy stall");
        spi_busy = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 1, 8'h77, 0, 1);
        tick();
        checkOutput("busy_grant", {6'd0, grant}, 8'h02);
        checkOutput("busy_ready", {7'd0, req1_ready}, 8'h00);
        tick();
        tick();
        checkOutput("busy_nostart", {7'd0, spi_start}, 8'h00);
        spi_busy = 1'b0;
        #1;
        checkOutput("busy_ready_rel", {7'd0, req1_ready}, 8'h01);
        tick();
        checkOutput("busy_start", {7'd0, spi_start}, 8'h01);
        checkOutput("busy_data", spi_data, 8'h77);
        req1_valid = 1'b0;
        engineDone();

        // Reset in WAIT, then a stray done
        $display("[TB] reset in WAIT");
        applyStimulus(1, 8'hE1, 1, 0, 0, 8'h00, 0, 0);
        tick();
        tick();
        reset = 1'b1;
        req0_valid = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("rw_grant", {6'd0, grant}, 8'h00);
        checkOutput("rw_hold", {7'd0, spi_hold_cs}, 8'h00);
        checkOutput("rw_start", {7'd0, spi_start}, 8'h00);
        checkOutput("rw_data", spi_data, 8'h00);
        checkOutput("rw_dc", {7'd0, spi_dc}, 8'h00);
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        checkOutput("stray_grant", {6'd0, grant}, 8'h00);
        checkOutput("stray_start", {7'd0, spi_start}, 8'h00);
        checkOutput("stray_hold", {7'd0, spi_hold_cs}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
